// File: rtl/ro_puf_reader_if.sv
// Response hand-off between the RO-PUF reader (master) and the root-of-trust key logic (slave).
// valid/ready: the master raises resp_valid with response and tie_seen stable and holds all three
// unchanged until a cycle where resp_valid && resp_ready; that cycle is the single transfer.
`timescale 1ns/1ps
interface ro_puf_reader_if #(
  parameter int N_BITS = 16
) ();
  logic [N_BITS-1:0] response;
  logic              resp_valid;
  logic              resp_ready;
  logic              tie_seen;

  modport master (output response, output resp_valid, output tie_seen, input resp_ready);
  modport slave  (input response, input resp_valid, input tie_seen, output resp_ready);
endinterface

// File: rtl/ro_puf_reader.sv
// RO-PUF sequencer: per bit it enables a ring pair, counts edges over a gate and resolves a >= b.
// Optional macro RO_PUF_MAJORITY_VOTE_EN measures each bit three times and stores the majority.
`timescale 1ns/1ps
module ro_puf_reader #(
  parameter int N_BITS     = 16,
  parameter int SETTLE_CYC = 8,
  parameter int WINDOW_CYC = 256,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            challenge_base,
  input  logic                  osc_a,
  input  logic                  osc_b,
  output logic                  puf_enable,
  output logic [1:0]            control_input,
  output logic                  busy,
  output logic [2:0]            state_dbg,
  ro_puf_reader_if.master       resp
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int TMAX  = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int IW_IX = $clog2(N_BITS);
  localparam int IW    = (IW_IX > 2) ? IW_IX : 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_nxt;
  logic [TW-1:0]      timer;
  logic [IW-1:0]      idx;
  logic [1:0]         base;
  logic [1:0]         sync_a, sync_b;
  logic               hist_a, hist_b;
  logic [CNT_W-1:0]   cnt_a, cnt_b;
  logic [N_BITS-1:0]  response_q;
  logic               tie_q;
  logic               valid;
  logic               last_pass;
  logic               last_cmp;
  logic               edge_a, edge_b;
  logic               bit_ge, bit_tie;

  assign edge_a   = sync_a[1] & ~hist_a;
  assign edge_b   = sync_b[1] & ~hist_b;
  assign bit_ge   = (cnt_a >= cnt_b);
  assign bit_tie  = (cnt_a == cnt_b);
  assign last_cmp = last_pass && (idx == IW'(N_BITS - 1));

  assign busy           = (state != S_IDLE);
  assign state_dbg      = state;
  assign control_input  = puf_enable ? (base + idx[1:0]) : 2'd0;
  assign resp.response   = response_q;
  assign resp.tie_seen   = tie_q;
  assign resp.resp_valid = valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    puf_enable = 1'b0;
    valid      = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SETTLE;
      S_SETTLE: begin
        puf_enable = 1'b1;
        if (timer == TW'(SETTLE_CYC - 1)) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        puf_enable = 1'b1;
        if (timer == TW'(WINDOW_CYC - 1)) state_nxt = S_COMPARE;
      end
      // Rings are disabled for this one cycle so every measurement starts from a fresh oscillation.
      S_COMPARE: state_nxt = last_cmp ? S_DONE : S_SETTLE;
      S_DONE: begin
        valid = 1'b1;
        if (resp.resp_ready) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a     <= '0;
      sync_b     <= '0;
      hist_a     <= 1'b0;
      hist_b     <= 1'b0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      timer      <= '0;
      idx        <= '0;
      base       <= '0;
      response_q <= '0;
      tie_q      <= 1'b0;
    end else begin
      sync_a <= {sync_a[0], osc_a};
      sync_b <= {sync_b[0], osc_b};
      hist_a <= sync_a[1];
      hist_b <= sync_b[1];
      if ((state == S_SETTLE || state == S_MEASURE) && state_nxt == state) timer <= timer + 1'b1;
      else                                                                  timer <= '0;
      case (state)
        S_IDLE: if (start) begin
          base       <= challenge_base;
          response_q <= '0;
          tie_q      <= 1'b0;
          idx        <= '0;
        end
        S_MEASURE: begin
          if (edge_a && cnt_a != CNT_MAX) cnt_a <= cnt_a + 1'b1;
          if (edge_b && cnt_b != CNT_MAX) cnt_b <= cnt_b + 1'b1;
        end
        S_COMPARE: begin
          cnt_a <= '0;
          cnt_b <= '0;
          tie_q <= tie_q | bit_tie;
          if (last_pass) begin
            response_q[idx[IW_IX-1:0]] <= stored_bit(bit_ge);
            idx                        <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RO_PUF_MAJORITY_VOTE_EN
  logic [1:0] pass_q;
  logic [1:0] votes_q;

  assign last_pass = (pass_q == 2'd2);

  function automatic logic stored_bit(input logic ge);
    return ((votes_q + {1'b0, ge}) >= 2'd2);
  endfunction

  // votes_q holds how many of the earlier passes of the current bit resolved to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q  <= '0;
      votes_q <= '0;
    end else if (state == S_IDLE && start) begin
      pass_q  <= '0;
      votes_q <= '0;
    end else if (state == S_COMPARE) begin
      if (last_pass) begin
        pass_q  <= '0;
        votes_q <= '0;
      end else begin
        pass_q  <= pass_q + 1'b1;
        votes_q <= votes_q + {1'b0, bit_ge};
      end
    end
  end
`else
  assign last_pass = 1'b1;

  function automatic logic stored_bit(input logic ge);
    return ge;
  endfunction
`endif

endmodule

// File: tb/tb_ro_puf_reader.sv
// Self-checking bench for ro_puf_reader: directed ring scenarios, a per-cycle timing model and
// a response scoreboard; a second small instance exercises counter saturation.
`timescale 1ns/1ps
module tb_ro_puf_reader;

  localparam int N = 16, S = 8, W = 256, P = S + W + 1;
`ifdef RO_PUF_MAJORITY_VOTE_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif
  localparam int LAT  = PASSES * N * P + 1;
  localparam int SN = 2, SS = 3, SWIN = 128, SP = SS + SWIN + 1;
  localparam int SLAT = PASSES * SN * SP + 1;

  localparam int SC_FAST_A = 0, SC_FAST_B = 1, SC_SEL23 = 2, SC_SAME = 3, SC_QUIET = 4, SC_WRONG1 = 5;

  // clock / reset / sources
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic osc_f = 1'b0, osc_s = 1'b0, osc_30 = 1'b0, osc_40 = 1'b0;
  initial begin #3; forever #50 osc_f  = ~osc_f;  end
  initial begin #7; forever #70 osc_s  = ~osc_s;  end
  initial begin #2; forever #15 osc_30 = ~osc_30; end
  initial begin #4; forever #20 osc_40 = ~osc_40; end

  // main DUT
  logic       start = 1'b0;
  logic [1:0] challenge_base = 2'd0;
  logic       osc_a, osc_b;
  logic       puf_enable;
  logic [1:0] control_input;
  logic       busy;
  logic [2:0] state_dbg;
  ro_puf_reader_if #(.N_BITS(N)) rif ();

  ro_puf_reader #(.N_BITS(N), .SETTLE_CYC(S), .WINDOW_CYC(W), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge_base(challenge_base),
    .osc_a(osc_a), .osc_b(osc_b), .puf_enable(puf_enable), .control_input(control_input),
    .busy(busy), .state_dbg(state_dbg), .resp(rif)
  );

  // small DUT with 4-bit counters
  logic       s_start = 1'b0;
  logic       s_puf_enable;
  logic [1:0] s_control_input;
  logic       s_busy;
  logic [2:0] s_state_dbg;
  ro_puf_reader_if #(.N_BITS(SN)) sif ();

  ro_puf_reader #(.N_BITS(SN), .SETTLE_CYC(SS), .WINDOW_CYC(SWIN), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .challenge_base(2'd0),
    .osc_a(osc_40), .osc_b(osc_30), .puf_enable(s_puf_enable), .control_input(s_control_input),
    .busy(s_busy), .state_dbg(s_state_dbg), .resp(sif)
  );

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];
  logic         tie_q[$];
  logic [N-1:0] last_w = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scenario model: ring period in ns per ring (0 = silent)
  int scen = SC_QUIET;
  int cur_pass = 0;

  function automatic int ring_period(input int sc, input bit ring_b, input logic [1:0] sel, input int pass);
    int pa, pb;
    case (sc)
      SC_FAST_A: begin pa = 100; pb = 140; end
      SC_FAST_B: begin pa = 140; pb = 100; end
      SC_SEL23:  begin pa = (sel >= 2'd2) ? 100 : 140; pb = (sel >= 2'd2) ? 140 : 100; end
      SC_SAME:   begin pa = 100; pb = 100; end
      SC_WRONG1: begin pa = (pass == 0) ? 140 : 100; pb = (pass == 0) ? 100 : 140; end
      default:   begin pa = 0;   pb = 0;   end
    endcase
    return ring_b ? pb : pa;
  endfunction

  function automatic logic ring_src(input int per, input logic f, input logic s);
    return (per == 100) ? f : (per == 140) ? s : 1'b0;
  endfunction

  always_comb begin
    osc_a = ring_src(ring_period(scen, 1'b0, control_input, cur_pass), osc_f, osc_s);
    osc_b = ring_src(ring_period(scen, 1'b1, control_input, cur_pass), osc_f, osc_s);
  end

  // a gathers at least as many edges as b when it is at least as fast; equal sources tie exactly
  function automatic bit a_wins(input int pa, input int pb);
    if (pa == pb) return 1'b1;
    if (pa == 0)  return 1'b0;
    if (pb == 0)  return 1'b1;
    return pa < pb;
  endfunction

  task automatic model_run(input logic [1:0] b, input int sc, output logic [N-1:0] w, output logic tie);
    w   = '0;
    tie = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [1:0] sel;
      int votes, pa, pb;
      sel   = 2'((b + i) % 4);
      votes = 0;
      for (int p = 0; p < PASSES; p++) begin
        pa = ring_period(sc, 1'b0, sel, p);
        pb = ring_period(sc, 1'b1, sel, p);
        if (a_wins(pa, pb)) votes++;
        if (pa == pb) tie = 1'b1;
      end
      w[i] = (2 * votes > PASSES);
    end
  endtask

  // per-cycle timing model: cycle t counts from 1 after the accepting edge
  int         t = 0;
  bit         trk = 1'b0;
  logic [1:0] run_base = 2'd0;
  int         m_seg, m_r, m_k;
  logic       m_en;
  logic [1:0] m_ci;

  always @(negedge clk) begin
    if (trk) begin
      t = t + 1;
      if (t <= PASSES * N * P) begin
        m_seg    = (t - 1) / P;
        m_r      = (t - 1) % P;
        m_k      = m_seg / PASSES;
        cur_pass = m_seg % PASSES;
        m_en     = (m_r < S + W);
        m_ci     = m_en ? 2'((run_base + m_k) % 4) : 2'd0;
        check("cyc_puf_enable", puf_enable, m_en);
        check("cyc_control_input", control_input, m_ci);
        check("cyc_busy", busy, 1'b1);
        check("cyc_resp_valid_low", rif.resp_valid, 1'b0);
      end else if (t == PASSES * N * P + 1) begin
        check("cyc_resp_valid_high", rif.resp_valid, 1'b1);
        check("cyc_done_puf_enable", puf_enable, 1'b0);
        check("cyc_done_busy", busy, 1'b1);
      end
    end
  end

  // driver tasks
  task automatic run_word(input logic [1:0] b, input int sc, input logic [N-1:0] lit_w, input logic lit_tie);
    logic [N-1:0] mw;
    logic         mt;
    int           lat;
    model_run(b, sc, mw, mt);
    exp_q.push_back(mw);
    tie_q.push_back(mt);
    scen     = sc;
    cur_pass = 0;
    @(negedge clk);
    challenge_base = b;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    run_base = b;
    t        = 0;
    trk      = 1'b1;
    lat      = 0;
    for (int c = 1; c <= LAT + 20; c++) begin
      @(negedge clk);
      if (rif.resp_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", lat, LAT);
    last_w = exp_q.pop_front();
    check("response_model", rif.response, last_w);
    check("tie_model", rif.tie_seen, tie_q.pop_front());
    check("response_literal", rif.response, lit_w);
    check("tie_literal", rif.tie_seen, lit_tie);
  endtask

  task automatic accept_resp(input bit with_start);
    rif.resp_ready = 1'b1;
    start          = with_start;
    @(negedge clk);
    rif.resp_ready = 1'b0;
    check("idle_after_ready", state_dbg, 3'd0);
    check("valid_drop", rif.resp_valid, 1'b0);
    check("busy_drop", busy, 1'b0);
    check("response_kept", rif.response, last_w);
    if (with_start) begin
      @(negedge clk);
      start = 1'b0;
      check("start_honoured_state", state_dbg, 3'd1);
      check("start_honoured_enable", puf_enable, 1'b1);
    end
  endtask

  task automatic hold_done(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      start = (i % 2 == 0);
      @(negedge clk);
      check("hold_valid", rif.resp_valid, 1'b1);
      check("hold_response", rif.response, last_w);
    end
    check("hold_state_done", state_dbg, 3'd4);
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_puf_enable"}, puf_enable, 1'b0);
    check({tag, "_control_input"}, control_input, 2'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_resp_valid"}, rif.resp_valid, 1'b0);
    check({tag, "_response"}, rif.response, '0);
    check({tag, "_tie_seen"}, rif.tie_seen, 1'b0);
    check({tag, "_state"}, state_dbg, 3'd0);
  endtask

  task automatic small_run();
    int lat;
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    lat     = 0;
    for (int c = 1; c <= SLAT + 20; c++) begin
      @(negedge clk);
      if (sif.resp_valid) begin
        lat = c;
        break;
      end
    end
    check("sat_latency", lat, SLAT);
    check("sat_response", sif.response, 2'b11);
    check("sat_tie", sif.tie_seen, 1'b1);
    sif.resp_ready = 1'b1;
    @(negedge clk);
    sif.resp_ready = 1'b0;
    check("sat_idle", s_state_dbg, 3'd0);
  endtask

  // reset-mid-MEASURE of bit 5 on a run that began from the honoured start (SEL23, base 2)
  task automatic reset_mid_measure();
    int tgt;
    tgt = 5 * PASSES * P + S + 100;
    repeat (tgt - 1) @(negedge clk);
    check("pre_rst_state_measure", state_dbg, 3'd2);
    check("pre_rst_enable", puf_enable, 1'b1);
    check("pre_rst_control", control_input, 2'd3);
    check("pre_rst_partial_response", rif.response, 16'h0013);
    trk = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("mid_rst");
    rst = 1'b0;
  endtask

  initial begin
    rif.resp_ready = 1'b0;
    sif.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    check("reset_sat_state", s_state_dbg, 3'd0);
    rst = 1'b0;
    fork
      small_run();
      begin
        run_word(2'd0, SC_FAST_A, 16'hFFFF, 1'b0);
        accept_resp(1'b0);
        run_word(2'd0, SC_FAST_B, 16'h0000, 1'b0);
        accept_resp(1'b0);
        run_word(2'd1, SC_SAME, 16'hFFFF, 1'b1);
        accept_resp(1'b0);
        run_word(2'd3, SC_QUIET, 16'hFFFF, 1'b1);
        accept_resp(1'b0);
        run_word(2'd2, SC_SEL23, 16'h3333, 1'b0);
        hold_done(50);
        accept_resp(1'b1);
        reset_mid_measure();
        run_word(2'd0, SC_FAST_B, 16'h0000, 1'b0);
        accept_resp(1'b0);
`ifdef RO_PUF_MAJORITY_VOTE_EN
        run_word(2'd0, SC_WRONG1, 16'hFFFF, 1'b0);
        accept_resp(1'b0);
`endif
      end
    join
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(PASSES * 600_000);
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/ro_puf_reader.md
Name: ro_puf_reader

Overview:
- Sequencer and measurement end of the ring-oscillator PUF.
- For each response bit it issues a challenge, meaning it drives the oscillator enable and the 2-bit ring select to the PUF pair.
- It then counts rising edges from the two selected rings over a fixed gate window and resolves the bit as count_a >= count_b.
- It assembles an N_BITS response word and hands it off with a valid/ready handshake to the root-of-trust key logic.

Parameters:
- N_BITS, 16, number of response bits per run (2..64).
- SETTLE_CYC, 8, clk cycles with rings enabled before counting starts (>=3).
- WINDOW_CYC, 256, clk cycles of the counting gate (>=1).
- CNT_W, 12, width of each edge counter, saturating.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new response run; sampled only in IDLE
- challenge_base  in  2  first ring select of the run; latched on accepted start
- osc_a  in  1  raw output of the selected ring, instance A (asynchronous)
- osc_b  in  1  raw output of the selected ring, instance B (asynchronous)
- puf_enable  out  1  enable to both oscillator banks
- control_input  out  2  ring select to both banks
- busy  out  1  high in every state except IDLE
- response  out  N_BITS  assembled response; response[i] is the i-th measured bit
- resp_valid  out  1  response is stable and offered
- resp_ready  in  1  consumer accepts response
- tie_seen  out  1  sticky per run: some bit had count_a == count_b

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - The state is IDLE.
  - Counters, bit index, synchronizers and response are cleared.
- Synchronizers: osc_a and osc_b each pass through a 2-FF synchronizer plus one history FF.
  - edge_x = sync2_x & ~hist_x.
  - An edge counts only if edge_x is high while in MEASURE.
- States:
  - IDLE: puf_enable=0.
    - start=1 latches challenge_base, clears response, tie_seen and the bit index, then goes to SETTLE.
  - SETTLE: puf_enable=1, control_input=(base+idx) mod 4 (2-bit wrap).
    - Lasts exactly SETTLE_CYC cycles, then goes to MEASURE.
  - MEASURE: puf_enable=1, control_input unchanged; counters increment on edges.
    - Each counter saturates at 2^CNT_W-1.
    - Lasts exactly WINDOW_CYC cycles.
  - COMPARE: one cycle.
    - response[idx] <= (cnt_a >= cnt_b).
    - tie_seen |= (cnt_a == cnt_b).
    - Counters are cleared and puf_enable=0 (this restarts the rings between bits).
    - idx is incremented.
    - If idx was N_BITS-1, go to DONE; otherwise go to SETTLE.
  - DONE: resp_valid=1; response and tie_seen are held stable.
    - resp_valid&resp_ready goes to IDLE, and resp_valid drops the next cycle.
    - response and tie_seen keep their value until the next accepted start.
- Latency with the start accepted at cycle 0:
  - Bit k resolves in the COMPARE at cycle (k+1)*(SETTLE_CYC+WINDOW_CYC+1).
  - resp_valid first goes high at cycle N_BITS*(SETTLE_CYC+WINDOW_CYC+1)+1. With default parameters this is 4241.
- Boundary conditions:
  - start while busy is ignored (not queued).
  - start coinciding with the resp_ready acceptance in DONE is ignored; it is honoured the next cycle in IDLE.
  - Equal counts give bit 1.
  - Both counters saturated gives bit 1 and sets tie_seen.
  - The challenge sequence wraps modulo 4: base=2 gives 2,3,0,1,2,...
  - rst in any state, including mid-MEASURE, returns everything to reset values on the next edge and drops puf_enable immediately at that edge.
  - No oscillator activity gives counts 0/0, so bit 1 and tie_seen=1.

Optional Feature:
- Macro: RO_PUF_MAJORITY_VOTE_EN.
- Defined:
  - Each bit is measured three times, each as a full SETTLE/MEASURE/COMPARE pass with the same control_input.
  - The stored bit is the majority of the three comparisons.
  - tie_seen is set if any pass tied.
  - The latency formula uses 3*N_BITS in place of N_BITS.
- Undefined: single measurement per bit as above, with no extra logic.

Test Plan:
- Use defaults and base=0. osc_a at period 10 clk, osc_b at period 14 clk -> response=16'hFFFF, tie_seen=0, and resp_valid rises at cycle 4241 after start.
- Swap osc_a and osc_b -> response=16'h0000, tie_seen=0. Check control_input runs 0,1,2,3,0,... per bit and puf_enable is low exactly one cycle between bits.
- Use base=2. Drive osc_a faster only when control_input is 2 or 3 -> response=16'h3333 (bits 0,1,4,5,... =1).
- Identical clocks on osc_a and osc_b -> response=16'hFFFF, tie_seen=1. Separately, CNT_W=4 with fast rings -> both saturate at 15, giving bit 1 and tie_seen=1.
- Hold resp_ready=0 for 50 cycles in DONE -> resp_valid and response stay stable and start is ignored. Then ready=1 -> IDLE next cycle.
- Assert rst mid-MEASURE of bit 5 -> the next cycle has all outputs 0 and state IDLE. A new start yields the full correct word. With RO_PUF_MAJORITY_VOTE_EN, one pass forced wrong per bit still gives the correct word.
